store_buffer: RTL and testbench

Store-side counterpart of the load-data extension path. It accepts byte, halfword and word stores from the MEM stage and aligns them into 32-bit write data plus a 4-bit byte-enable. Accepted stores sit in a small FIFO and drain to the data RAM over a req/ack handshake. The block also flags loads that hit a pending store, so the hazard unit can stall them.

---
 rtl/store_buffer_pkg.sv | 24 ++
 rtl/store_buffer_if.sv | 35 +++
 rtl/store_lane_align.sv | 36 +++
 rtl/store_buffer.sv | 151 +++++++++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store size codes, drain FSM states and
// the aligned FIFO entry format.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    ST_B = 2'b00,
    ST_H = 2'b01,
    ST_W = 2'b10
  } sb_size_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drain_state_e;

  // Lanes are already aligned when an entry is written, so the drain side
  // only replays them.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store port, data-RAM write port and the
// load-hazard probe. The master modport is the pipeline/RAM side.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  sb_size_e    st_size;
  logic        st_ale;

  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;

  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        sb_empty;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack, ld_valid, ld_addr,
    input  st_ready, st_ale, mem_req, mem_addr, mem_wdata, mem_we,
           ld_conflict, sb_empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack, ld_valid, ld_addr,
    output st_ready, st_ale, mem_req, mem_addr, mem_wdata, mem_we,
           ld_conflict, sb_empty
  );
endinterface

// File: rtl/store_lane_align.sv
// Combinational lane steering: replicates store data across byte lanes,
// builds the byte-enable mask and flags misaligned halfword/word stores.
module store_lane_align
  import store_buffer_pkg::*;
(
  input  sb_size_e    size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  we,
  output logic        misaligned
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    wdata      = data;
    we         = 4'b1111;
    misaligned = 1'b0;
    case (size)
      ST_B: begin
        wdata = {4{data[7:0]}};
        we    = 4'b0001 << addr_lo;
      end
      ST_H: begin
        wdata      = {2{data[15:0]}};
        we         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns MEM-stage stores, queues them in a DEPTH-entry FIFO,
// drains them to the data RAM over req/ack and flags loads hitting a queued word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  store_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  drain_state_e state_q, state_d;
  cnt_t         count_q, count_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  ptr_t         wr_ptr_q, wr_ptr_d;
  sb_entry_t    fifo_q [DEPTH];
  sb_entry_t    fifo_d [DEPTH];
  sb_entry_t    head_q, head_d;
  logic         st_ale_q, st_ale_d;

  logic [31:0]  al_wdata;
  logic [3:0]   al_we;
  logic         al_misaligned;
  sb_entry_t    new_entry;
  logic         st_ready;
  logic         accept;
  logic         push;
  logic         pop;
  logic         ld_hit;
  logic         unused_ld_lo;

  store_lane_align u_align (
    .size       (bus.st_size),
    .addr_lo    (bus.st_addr[1:0]),
    .data       (bus.st_data),
    .wdata      (al_wdata),
    .we         (al_we),
    .misaligned (al_misaligned)
  );

  assign new_entry = '{word_addr: bus.st_addr[31:2], wdata: al_wdata, we: al_we};

  // Full is judged on the registered count alone; a same-cycle pop never frees a slot.
  assign st_ready = (count_q < cnt_t'(DEPTH));
  assign accept   = bus.st_valid && st_ready;
  assign push     = accept && !al_misaligned;
  assign pop      = (state_q == S_REQ) && bus.mem_ack;

  // Slot i is live when its distance from the read pointer is below the count.
  function automatic logic slot_live(input int unsigned idx, input ptr_t rd, input cnt_t cnt);
    ptr_t off;
    off = ptr_t'(idx) - rd;
    return (cnt_t'(off) < cnt);
  endfunction

  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_live(i, rd_ptr_q, count_q) &&
          (fifo_q[i].word_addr == bus.ld_addr[31:2])) begin
        ld_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fifo_d   = fifo_q;
    head_d   = head_q;
    st_ale_d = accept && al_misaligned;

    if (push) begin
      fifo_d[wr_ptr_q] = new_entry;
      wr_ptr_d         = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) || push) begin
          state_d = S_REQ;
          head_d  = (count_q != '0) ? fifo_q[rd_ptr_q] : new_entry;
        end
      end
      default: begin
        if (pop) begin
          if (count_d == '0) begin
            state_d = S_IDLE;
          end else begin
            // With only the departing entry left, the new head is the one being pushed now.
            head_d = (count_q > cnt_t'(1)) ? fifo_q[rd_ptr_d] : new_entry;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      head_q   <= '0;
      st_ale_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      head_q   <= head_d;
      st_ale_q <= st_ale_d;
    end
  end

  // NOTE: the entry array is not reset; count and pointers decide which slots
  // are meaningful, so clearing storage would only cost reset fan-out.
  always_ff @(posedge cpu_clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.st_ready    = st_ready;
  assign bus.st_ale      = st_ale_q;
  assign bus.mem_req     = (state_q == S_REQ);
  assign bus.mem_addr    = {head_q.word_addr, 2'b00};
  assign bus.mem_wdata   = head_q.wdata;
  assign bus.mem_we      = head_q.we;
  assign bus.ld_conflict = bus.ld_valid && ld_hit;
  assign bus.sb_empty    = (count_q == '0);

  assign unused_ld_lo = ^bus.ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=2): a table of single-store
// alignment vectors followed by directed multi-cycle sequences.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer_if sb ();

  store_buffer #(.DEPTH(2)) dut (
    .cpu_clk (clk),
    .cpu_rst (rst),
    .bus     (sb)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    sb_size_e    size;
    logic        exp_ale;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_we;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb.st_valid = 1'b0;
    sb.st_addr  = '0;
    sb.st_data  = '0;
    sb.st_size  = ST_B;
    sb.mem_ack  = 1'b0;
    sb.ld_valid = 1'b0;
    sb.ld_addr  = '0;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input sb_size_e size);
    sb.st_valid = 1'b1;
    sb.st_addr  = addr;
    sb.st_data  = data;
    sb.st_size  = size;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1003, 32'h0000_00A5, ST_B, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
    vecs[1] = '{32'h0000_2002, 32'h1234_BEEF, ST_H, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    vecs[2] = '{32'h0000_2001, 32'h1111_2222, ST_W, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[3] = '{32'h0000_4000, 32'hDEAD_BEEF, ST_W, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111};
    vecs[4] = '{32'h0000_5001, 32'h1234_56C3, ST_B, 1'b0, 32'h0000_5000, 32'hC3C3_C3C3, 4'b0010};
    vecs[5] = '{32'h0000_5000, 32'hAAAA_5678, ST_H, 1'b0, 32'h0000_5000, 32'h5678_5678, 4'b0011};
    vecs[6] = '{32'h0000_5003, 32'h0000_9999, ST_H, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[7] = '{32'h0000_5002, 32'h0000_7777, ST_W, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[8] = '{32'hFFFF_6002, 32'h0000_0011, ST_B, 1'b0, 32'hFFFF_6000, 32'h1111_1111, 4'b0100};

    // Reset state, probed with a live load so ld_conflict has something to reject.
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.ld_valid = 1'b1;
    #1;
    check("rst_mem_req",     32'(sb.mem_req),     32'd0);
    check("rst_mem_addr",    sb.mem_addr,         32'd0);
    check("rst_mem_wdata",   sb.mem_wdata,        32'd0);
    check("rst_mem_we",      32'(sb.mem_we),      32'd0);
    check("rst_st_ale",      32'(sb.st_ale),      32'd0);
    check("rst_st_ready",    32'(sb.st_ready),    32'd1);
    check("rst_sb_empty",    32'(sb.sb_empty),    32'd1);
    check("rst_ld_conflict", 32'(sb.ld_conflict), 32'd0);
    sb.ld_valid = 1'b0;
    step();

    // Single stores: accept, inspect the request, then ack one cycle later.
    for (int i = 0; i < 9; i++) begin
      drive_store(vecs[i].addr, vecs[i].data, vecs[i].size);
      step();
      sb.st_valid = 1'b0;
      check($sformatf("v%0d_st_ale", i),   32'(sb.st_ale),   32'(vecs[i].exp_ale));
      check($sformatf("v%0d_mem_req", i),  32'(sb.mem_req),  32'(!vecs[i].exp_ale));
      check($sformatf("v%0d_sb_empty", i), 32'(sb.sb_empty), 32'(vecs[i].exp_ale));
      if (!vecs[i].exp_ale) begin
        check($sformatf("v%0d_mem_addr", i),  sb.mem_addr,      vecs[i].exp_maddr);
        check($sformatf("v%0d_mem_wdata", i), sb.mem_wdata,     vecs[i].exp_wdata);
        check($sformatf("v%0d_mem_we", i),    32'(sb.mem_we),   32'(vecs[i].exp_we));
      end
      sb.mem_ack = 1'b1;
      step();
      sb.mem_ack = 1'b0;
      check($sformatf("v%0d_post_req", i),   32'(sb.mem_req),  32'd0);
      check($sformatf("v%0d_post_empty", i), 32'(sb.sb_empty), 32'd1);
      check($sformatf("v%0d_post_ale", i),   32'(sb.st_ale),   32'd0);
    end

    // Fill with ack low: third store must be refused without st_ale.
    drive_store(32'h0000_0100, 32'h0000_0001, ST_W);
    step();
    drive_store(32'h0000_0104, 32'h0000_0002, ST_W);
    step();
    check("fill_ready_low", 32'(sb.st_ready), 32'd0);
    drive_store(32'h0000_0108, 32'h0000_0003, ST_W);
    step();
    sb.st_valid = 1'b0;
    check("fill_no_ale",  32'(sb.st_ale),  32'd0);
    check("fill_head_a",  sb.mem_addr,     32'h0000_0100);
    check("fill_head_wd", sb.mem_wdata,    32'h0000_0001);
    check("fill_hold_rq", 32'(sb.mem_req), 32'd1);
    sb.mem_ack = 1'b1;
    step();
    check("fill_2nd_req",   32'(sb.mem_req),  32'd1);
    check("fill_2nd_addr",  sb.mem_addr,      32'h0000_0104);
    check("fill_2nd_wdata", sb.mem_wdata,     32'h0000_0002);
    check("fill_2nd_ready", 32'(sb.st_ready), 32'd1);
    step();
    sb.mem_ack = 1'b0;
    check("fill_done_req",   32'(sb.mem_req),  32'd0);
    check("fill_done_empty", 32'(sb.sb_empty), 32'd1);

    // Streaming with ack held high: push and pop on the same edge at count=1.
    sb.mem_ack = 1'b1;
    drive_store(32'h0000_7000, 32'h0000_000A, ST_W);
    step();
    check("strm_a_req",  32'(sb.mem_req), 32'd1);
    check("strm_a_addr", sb.mem_addr,     32'h0000_7000);
    drive_store(32'h0000_7004, 32'h0000_000B, ST_W);
    step();
    check("strm_b_addr",  sb.mem_addr,      32'h0000_7004);
    check("strm_b_wdata", sb.mem_wdata,     32'h0000_000B);
    check("strm_b_empty", 32'(sb.sb_empty), 32'd0);
    drive_store(32'h0000_7008, 32'h0000_000C, ST_W);
    step();
    check("strm_c_addr", sb.mem_addr,     32'h0000_7008);
    check("strm_c_req",  32'(sb.mem_req), 32'd1);
    sb.st_valid = 1'b0;
    step();
    sb.mem_ack = 1'b0;
    check("strm_end_req",   32'(sb.mem_req),  32'd0);
    check("strm_end_empty", 32'(sb.sb_empty), 32'd1);

    // Load conflict: same-cycle enqueue is not compared, next cycle it is.
    drive_store(32'h0000_3000, 32'h0000_0077, ST_W);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h0000_3002;
    #1;
    check("conf_same_cycle", 32'(sb.ld_conflict), 32'd0);
    step();
    sb.st_valid = 1'b0;
    check("conf_hit", 32'(sb.ld_conflict), 32'd1);
    sb.ld_addr = 32'h0000_3004;
    #1;
    check("conf_other_word", 32'(sb.ld_conflict), 32'd0);
    sb.ld_addr = 32'h0000_3002;
    sb.ld_valid = 1'b0;
    #1;
    check("conf_no_ld_valid", 32'(sb.ld_conflict), 32'd0);
    sb.ld_valid = 1'b1;
    sb.mem_ack  = 1'b1;
    step();
    sb.mem_ack = 1'b0;
    check("conf_after_pop", 32'(sb.ld_conflict), 32'd0);
    sb.ld_valid = 1'b0;

    // Reset while a request is outstanding with two entries queued.
    drive_store(32'h0000_8000, 32'h0000_00F0, ST_W);
    step();
    drive_store(32'h0000_8004, 32'h0000_00F1, ST_W);
    step();
    sb.st_valid = 1'b0;
    check("mid_req",   32'(sb.mem_req),  32'd1);
    check("mid_ready", 32'(sb.st_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_req",   32'(sb.mem_req),  32'd0);
    check("mid_rst_we",    32'(sb.mem_we),   32'd0);
    check("mid_rst_empty", 32'(sb.sb_empty), 32'd1);
    check("mid_rst_ready", 32'(sb.st_ready), 32'd1);
    step();
    check("mid_rst_stay_idle", 32'(sb.mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
